// File: rtl/deserializer.sv
// Byte-stream deserializer: HEADER, NUM_CHANNELS data bytes, FOOTER -> one parallel frame.
// Latency: frame_data/frame_valid update on the edge that samples the footer byte.
// Backpressure: one-deep output slot; a good frame arriving while the slot is held is dropped (overflow).
module deserializer #(
   parameter logic [7:0] HEADER       = 8'hAA,
   parameter logic [7:0] FOOTER       = 8'hFF,
   parameter int         NUM_CHANNELS = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                din,
   input  logic                      din_valid,
   output logic [8*NUM_CHANNELS-1:0] frame_data,
   output logic                      frame_valid,
   input  logic                      frame_ready,
   output logic                      frame_err,
   output logic                      overflow,
   output logic [15:0]               frame_count,
   output logic [15:0]               err_count
);

   localparam int               IDX_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

   typedef enum logic [1:0] {S_HUNT, S_DATA, S_CHECK} state_t;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [IDX_W-1:0]             r_idx;
   logic [IDX_W-1:0]             w_idx_nxt;
   logic [NUM_CHANNELS-1:0][7:0] r_cap;
   logic                         w_cap_we;
   logic                         w_good;
   logic                         w_bad;
   logic                         w_commit;
   logic                         w_drop;

   logic [NUM_CHANNELS-1:0][7:0] r_data;
   logic                         r_valid;
   logic                         r_err;
   logic                         r_ovf;
   logic [15:0]                  r_fcnt;
   logic [15:0]                  r_ecnt;

   // State and channel index register; everything advances only on valid bytes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_HUNT;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state decode: hunt for header, collect payload, then judge the footer byte.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cap_we    = 1'b0;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      if (din_valid) begin
         case (r_state)
            S_HUNT: begin
               if (din == HEADER) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_DATA;
               end
            end
            S_DATA: begin
               // Marker values inside the payload are plain data; no resync here.
               w_cap_we = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = S_CHECK;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
            S_CHECK: begin
               w_state_nxt = S_HUNT;
               if (din == FOOTER) begin
                  w_good = 1'b1;
               end else begin
                  w_bad = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_HUNT;
            end
         endcase
      end
   end

   // A good frame lands only if the slot is free or being emptied this very cycle.
   assign w_commit = w_good & (~r_valid | frame_ready);
   assign w_drop   = w_good & r_valid & ~frame_ready;

   // Capture buffer is private to reception so frame_data never sees partial frames.
   always_ff @(posedge clk) begin
      if (w_cap_we) begin
         r_cap[r_idx] <= din;
      end
   end

   // Output slot, event pulses and statistics counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_ovf   <= 1'b0;
         r_fcnt  <= '0;
         r_ecnt  <= '0;
      end else begin
         r_err <= w_bad;
         r_ovf <= w_drop;
         if (w_commit) begin
            r_data  <= r_cap;
            r_valid <= 1'b1;
            r_fcnt  <= r_fcnt + 16'd1;
         end else if (r_valid && frame_ready) begin
            r_valid <= 1'b0;
         end
         if ((w_bad || w_drop) && (r_ecnt != 16'hFFFF)) begin
            r_ecnt <= r_ecnt + 16'd1;
         end
      end
   end

   assign frame_data  = r_data;
   assign frame_valid = r_valid;
   assign frame_err   = r_err;
   assign overflow    = r_ovf;
   assign frame_count = r_fcnt;
   assign err_count   = r_ecnt;

endmodule
